// File: rtl/lilypad_rows.sv
// Four free-running river rows of lily pads: per-frame phase counters, wrapping X positions, frog-on-pad / frog-in-water detection.
// Latency: positions, phases and speeds update on the frame edge; collision flags are registered one frame_clk after FrogX/FrogY.
// Backpressure: none, the block advances every frame. `define LPAD_LEVEL_EN enables level_up speed-ups; otherwise level_up is ignored.
module lilypad_rows #(
    parameter int ROW_Y0    = 80,
    parameter int PAD_W     = 120,
    parameter int STEP      = 40,
    parameter int X_MAX     = 640,
    parameter int SPEED0    = 30,
    parameter int SPEED1    = 20,
    parameter int SPEED2    = 40,
    parameter int SPEED3    = 15,
    parameter int SPEED_DEC = 2
) (
    input  logic        frame_clk,
    input  logic        Reset_n,
    input  logic [10:0] FrogX,
    input  logic [10:0] FrogY,
    input  logic        level_up,
    output logic [10:0] LPad_X [0:3],
    output logic [10:0] LPad_Y [0:3],
    output logic [10:0] LPad_Width,
    output logic [5:0]  LPad_Speed [0:3],
    output logic [5:0]  LPad_Remainder_Count [3:0],
    output logic        LPad_Direction [0:3],
    output logic [3:0]  LPad_Collision,
    output logic        Water_Collision
);

    localparam int          NROWS     = 4;
    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [10:0] XMAX_W    = 11'(X_MAX);
    // The frog is 40 px wide, so it is fully on a pad when its offset into the pad is at most PAD_W-40.
    localparam logic [10:0] OFF_MAX   = 11'(PAD_W - 40);
    localparam logic [3:0]  DIR_RIGHT = 4'b1010;
    localparam logic [5:0]  SPD_FLOOR = 6'd4;
    localparam logic [5:0]  DEC_W     = 6'(SPEED_DEC);

    function automatic logic [5:0] speed_reset(input int row);
        case (row)
            0:       return 6'(SPEED0);
            1:       return 6'(SPEED1);
            2:       return 6'(SPEED2);
            default: return 6'(SPEED3);
        endcase
    endfunction

    function automatic logic [10:0] row_y(input int row);
        return 11'(ROW_Y0 + 40 * row);
    endfunction

    function automatic logic [10:0] step_x(input logic [10:0] x, input logic right);
        logic [10:0] r;
        if (right)
            r = (x + STEP_W >= XMAX_W) ? x + STEP_W - XMAX_W : x + STEP_W;
        else
            r = (x < STEP_W) ? x + XMAX_W - STEP_W : x - STEP_W;
        return r;
    endfunction

    logic [5:0]  cnt_q [NROWS];
    logic [5:0]  cnt_d [NROWS];
    logic [5:0]  spd_q [NROWS];
    logic [5:0]  spd_d [NROWS];
    logic [10:0] x_q   [NROWS];
    logic [10:0] x_d   [NROWS];
    logic [10:0] off   [NROWS];
    logic [3:0]  coll_d;
    logic        in_river;
    logic        water_d;
    logic        lvl;

`ifdef LPAD_LEVEL_EN
    assign lvl = level_up;
`else
    logic unused_level_up;
    assign unused_level_up = level_up;
    assign lvl = 1'b0;
`endif

    // A level-up edge re-phases every row and suppresses any step that was due.
    always_comb begin
        for (int i = 0; i < NROWS; i++) begin
            cnt_d[i] = cnt_q[i];
            spd_d[i] = spd_q[i];
            x_d[i]   = x_q[i];
            if (lvl) begin
                cnt_d[i] = 6'd0;
                spd_d[i] = (spd_q[i] >= SPD_FLOOR + DEC_W) ? spd_q[i] - DEC_W : SPD_FLOOR;
            end else if (cnt_q[i] == spd_q[i] - 6'd1) begin
                cnt_d[i] = 6'd0;
                x_d[i]   = step_x(x_q[i], DIR_RIGHT[i]);
            end else begin
                cnt_d[i] = cnt_q[i] + 6'd1;
            end
        end
    end

    // Offset of the frog into each pad, modulo the screen width, against the pre-step position.
    always_comb begin
        coll_d   = '0;
        in_river = 1'b0;
        for (int i = 0; i < NROWS; i++) begin
            off[i] = FrogX - x_q[i];
            if (FrogX < x_q[i])
                off[i] = off[i] + XMAX_W;
            coll_d[i] = (FrogY == row_y(i)) && (off[i] <= OFF_MAX);
            in_river  = in_river | (FrogY == row_y(i));
        end
        water_d = in_river && (coll_d == 4'd0);
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NROWS; i++) begin
                cnt_q[i] <= 6'd0;
                spd_q[i] <= speed_reset(i);
                x_q[i]   <= 11'(160 * i);
            end
            LPad_Collision  <= 4'd0;
            Water_Collision <= 1'b0;
        end else begin
            for (int i = 0; i < NROWS; i++) begin
                cnt_q[i] <= cnt_d[i];
                spd_q[i] <= spd_d[i];
                x_q[i]   <= x_d[i];
            end
            LPad_Collision  <= coll_d;
            Water_Collision <= water_d;
        end
    end

    always_comb begin
        LPad_Width = 11'(PAD_W);
        for (int i = 0; i < NROWS; i++) begin
            LPad_X[i]               = x_q[i];
            LPad_Y[i]               = row_y(i);
            LPad_Speed[i]           = spd_q[i];
            LPad_Remainder_Count[i] = cnt_q[i];
            LPad_Direction[i]       = DIR_RIGHT[i];
        end
    end

endmodule

// File: tb/tb_lilypad_rows.sv
// Bench for lilypad_rows: collision vector table, hand-written wrap/level/reset sequences, then randomized frames vs. a reference model.
module tb_lilypad_rows;

    logic        frame_clk = 1'b0;
    logic        Reset_n;
    logic [10:0] FrogX, FrogY;
    logic        level_up;
    logic [10:0] LPad_X [0:3];
    logic [10:0] LPad_Y [0:3];
    logic [10:0] LPad_Width;
    logic [5:0]  LPad_Speed [0:3];
    logic [5:0]  LPad_Remainder_Count [3:0];
    logic        LPad_Direction [0:3];
    logic [3:0]  LPad_Collision;
    logic        Water_Collision;

    always #5 frame_clk = ~frame_clk;

    lilypad_rows dut (
        .frame_clk            (frame_clk),
        .Reset_n              (Reset_n),
        .FrogX                (FrogX),
        .FrogY                (FrogY),
        .level_up             (level_up),
        .LPad_X               (LPad_X),
        .LPad_Y               (LPad_Y),
        .LPad_Width           (LPad_Width),
        .LPad_Speed           (LPad_Speed),
        .LPad_Remainder_Count (LPad_Remainder_Count),
        .LPad_Direction       (LPad_Direction),
        .LPad_Collision       (LPad_Collision),
        .Water_Collision      (Water_Collision)
    );

`ifdef LPAD_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: each row tracks frames elapsed since its last re-phase and its absolute position.
    int spd_init [4] = '{30, 20, 40, 15};
    int mx  [4];
    int mel [4];
    int ms  [4];
    logic [3:0] mcoll;
    logic       mwater;

    typedef struct {
        int         fx;
        int         fy;
        logic [3:0] coll;
        logic       water;
    } vec_t;
    vec_t tbl [13];

    function automatic int wrap(input int v);
        return ((v % 640) + 640) % 640;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i]  = 160 * i;
            mel[i] = 0;
            ms[i]  = spd_init[i];
        end
        mcoll  = 4'd0;
        mwater = 1'b0;
    endtask

    task automatic model_edge(input int fx, input int fy, input bit lvl);
        logic river;
        river = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // frog [fx, fx+40) must lie within pad [x, x+PAD_W) on the circular screen
            mcoll[i] = (fy == 80 + 40 * i) && (wrap(fx - mx[i]) + 40 <= 120);
            if (fy == 80 + 40 * i) river = 1'b1;
        end
        mwater = river && (mcoll == 4'd0);
        for (int i = 0; i < 4; i++) begin
            if (lvl && LVL_EN) begin
                mel[i] = 0;
                ms[i]  = (ms[i] - 2 < 4) ? 4 : ms[i] - 2;
            end else begin
                mel[i]++;
                if (mel[i] % ms[i] == 0)
                    mx[i] = wrap(mx[i] + ((i % 2 == 1) ? 40 : -40));
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("x%0d", i), 32'(LPad_X[i]), 32'(mx[i]));
            chk($sformatf("rem%0d", i), 32'(LPad_Remainder_Count[i]), 32'(mel[i] % ms[i]));
            chk($sformatf("speed%0d", i), 32'(LPad_Speed[i]), 32'(ms[i]));
        end
        chk("collision", 32'(LPad_Collision), 32'(mcoll));
        chk("water", 32'(Water_Collision), 32'(mwater));
    endtask

    // Called at a negedge: drive inputs, let one frame edge pass, compare at the next negedge.
    task automatic tick(input int fx, input int fy, input bit lvl);
        FrogX    = 11'(fx);
        FrogY    = 11'(fy);
        level_up = lvl;
        @(posedge frame_clk);
        model_edge(fx, fy, lvl);
        @(negedge frame_clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick(40, 440, 1'b0);
    endtask

    task automatic do_reset();
        Reset_n  = 1'b0;
        level_up = 1'b0;
        model_reset();
        @(negedge frame_clk);
        check_all();
        Reset_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{40,  80,  4'b0001, 1'b0};
        tbl[1]  = '{120, 80,  4'b0000, 1'b1};
        tbl[2]  = '{0,   80,  4'b0001, 1'b0};
        tbl[3]  = '{80,  80,  4'b0001, 1'b0};
        tbl[4]  = '{81,  80,  4'b0000, 1'b1};
        tbl[5]  = '{200, 120, 4'b0010, 1'b0};
        tbl[6]  = '{240, 120, 4'b0010, 1'b0};
        tbl[7]  = '{320, 160, 4'b0100, 1'b0};
        tbl[8]  = '{600, 200, 4'b0000, 1'b1};
        tbl[9]  = '{560, 200, 4'b1000, 1'b0};
        tbl[10] = '{40,  440, 4'b0000, 1'b0};
        tbl[11] = '{479, 200, 4'b0000, 1'b1};
        tbl[12] = '{0,   0,   4'b0000, 1'b0};

        FrogX    = 11'd0;
        FrogY    = 11'd440;
        level_up = 1'b0;
        Reset_n  = 1'b0;
        @(negedge frame_clk);
        do_reset();
        chk("width", 32'(LPad_Width), 32'd120);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("y%0d", i), 32'(LPad_Y[i]), 32'(80 + 40 * i));
            chk($sformatf("dir%0d", i), 32'(LPad_Direction[i]), 32'(i % 2));
        end

        // Pads sit at their reset positions for the first 14 frames.
        for (int v = 0; v < 13; v++) begin
            tick(tbl[v].fx, tbl[v].fy, 1'b0);
            chk($sformatf("tbl%0d_coll", v), 32'(LPad_Collision), 32'(tbl[v].coll));
            chk($sformatf("tbl%0d_water", v), 32'(Water_Collision), 32'(tbl[v].water));
        end

        do_reset();
        run(14);
        chk("row3_before_step", 32'(LPad_X[3]), 32'd480);
        chk("row3_rem14", 32'(LPad_Remainder_Count[3]), 32'd14);
        run(1);
        chk("row3_first_step", 32'(LPad_X[3]), 32'd520);
        chk("row3_rem0", 32'(LPad_Remainder_Count[3]), 32'd0);
        run(14);
        chk("row0_before_step", 32'(LPad_X[0]), 32'd0);
        run(1);
        chk("row0_left_wrap", 32'(LPad_X[0]), 32'd600);
        run(190);
        chk("row1_at_600", 32'(LPad_X[1]), 32'd600);
        run(20);
        chk("row1_right_wrap", 32'(LPad_X[1]), 32'd0);
        chk("row1_rem0", 32'(LPad_Remainder_Count[1]), 32'd0);
        run(1);
        chk("row1_rem1", 32'(LPad_Remainder_Count[1]), 32'd1);
        run(1);
        chk("row1_rem2", 32'(LPad_Remainder_Count[1]), 32'd2);
        run(118);
        chk("row2_at_600", 32'(LPad_X[2]), 32'd600);
        tick(0, 160, 1'b0);
        chk("wrap_pad_left_edge", 32'(LPad_Collision), 32'b0100);
        tick(40, 160, 1'b0);
        chk("wrap_pad_right_limit", 32'(LPad_Collision), 32'b0100);
        tick(80, 160, 1'b0);
        chk("wrap_pad_off_coll", 32'(LPad_Collision), 32'b0000);
        chk("wrap_pad_off_water", 32'(Water_Collision), 32'd1);
        tick(80, 440, 1'b0);
        chk("bank_water", 32'(Water_Collision), 32'd0);

        // level_up lands on the edge where row 3 is due.
        do_reset();
        run(14);
        tick(40, 440, 1'b1);
`ifdef LPAD_LEVEL_EN
        chk("lvl_no_step", 32'(LPad_X[3]), 32'd480);
        chk("lvl_rem0", 32'(LPad_Remainder_Count[0]), 32'd0);
        chk("lvl_speed0", 32'(LPad_Speed[0]), 32'd28);
        chk("lvl_speed3", 32'(LPad_Speed[3]), 32'd13);
        for (int k = 0; k < 5; k++) tick(40, 440, 1'b1);
        chk("lvl_speed3_floor", 32'(LPad_Speed[3]), 32'd4);
        chk("lvl_speed0_after6", 32'(LPad_Speed[0]), 32'd18);
`else
        chk("nolvl_step", 32'(LPad_X[3]), 32'd520);
        chk("nolvl_speed3", 32'(LPad_Speed[3]), 32'd15);
        for (int k = 0; k < 5; k++) tick(40, 440, 1'b1);
        chk("nolvl_speed0", 32'(LPad_Speed[0]), 32'd30);
`endif

        // Asynchronous reset between edges while the frog is on a pad.
        tick(wrap(mx[0] + 10), 80, 1'b0);
        chk("pre_reset_coll", 32'(LPad_Collision), 32'b0001);
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge frame_clk);
        Reset_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            int r, fx, fy;
            r = int'($urandom_range(0, 5));
            if (r < 4) fy = 80 + 40 * r;
            else if (r == 4) fy = 440;
            else fy = int'($urandom_range(0, 479));
            if ($urandom_range(0, 1) == 1)
                fx = wrap(mx[$urandom_range(0, 3)] + int'($urandom_range(0, 90)) - 5);
            else
                fx = int'($urandom_range(0, 639));
            tick(fx, fy, $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
